linebuf_ctrl: RTL and testbench
===============================

LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 320: pixels per line, and the depth of the attached 1-bit line RAM.
REQ-002 SHALL have parameter IMG_H, default 240: lines per frame.
REQ-003 SHALL have parameter AW, default 11: RAM address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: binary pixel present this cycle.
REQ-007 SHALL have port in_sof, input, 1 bit: start of frame; meaningful only when in_valid=1.
REQ-008 SHALL have port in_pixel, input, 1 bit: binary pixel value.
REQ-009 SHALL have port ram_we, output, 1 bit: line RAM write enable.
REQ-010 SHALL have port ram_waddr, output, AW bits: line RAM write address.
REQ-011 SHALL have port ram_raddr, output, AW bits: line RAM read address.
REQ-012 SHALL have port ram_di, output, 1 bit: line RAM write data.
REQ-013 SHALL have port ram_dout, input, 1 bit: line RAM read data, 1-cycle latency, read-before-write.
REQ-014 SHALL have port out_valid, output, 1 bit: output pixel pair valid.
REQ-015 SHALL have port out_cur, output, 1 bit: current pixel.
REQ-016 SHALL have port out_up, output, 1 bit: pixel at the same column on the previous line.
REQ-017 SHALL have port out_x, output, AW bits: column of the output pixel.
REQ-018 SHALL have port out_y, output, 9 bits: row of the output pixel.
REQ-019 SHALL have port out_eol, output, 1 bit: last pixel of a line.
REQ-020 SHALL have port out_eof, output, 1 bit: last pixel of a frame.
REQ-021 SHALL have port busy, output, 1 bit: high while the FSM is in ACTIVE.
REQ-022 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a restarted frame.

Function
REQ-023 SHALL implement FSM states IDLE and ACTIVE; busy=1 exactly when in ACTIVE.
REQ-024 In IDLE, SHALL accept a pixel only when in_valid=1 and in_sof=1; that pixel is (x=0,y=0) and the FSM moves to ACTIVE.
REQ-025 In IDLE, SHALL ignore in_valid=1 with in_sof=0: no RAM write, no output.
REQ-026 In ACTIVE, SHALL accept every in_valid=1 cycle; in_valid=0 cycles are stalls that hold x/y unchanged.
REQ-027 Per accepted pixel, SHALL drive combinationally in the same cycle: ram_we=1, ram_waddr=ram_raddr=x, ram_di=in_pixel; otherwise ram_we=0 and addresses hold x.
REQ-028 SHALL obtain the previous line's pixel from read-before-write at the same address, so a single IMG_W-deep RAM suffices.
REQ-029 SHALL assert out_valid exactly 1 cycle after each accepted pixel, with out_cur, out_x and out_y registered from the accept cycle.
REQ-030 SHALL output out_up = ram_dout when out_y>0, and out_up = 0 when out_y=0 (stale RAM masked).
REQ-031 Counters: x increments per accepted pixel; at x=IMG_W-1, x wraps to 0 and y increments; out_eol=1 with the pixel at x=IMG_W-1.
REQ-032 At (IMG_W-1, IMG_H-1): out_eol=out_eof=1 on its output cycle; the FSM returns to IDLE in the cycle after the accept; x and y clear to 0.
REQ-033 In ACTIVE, in_valid=1 with in_sof=1 SHALL restart the frame: the pixel becomes (0,0), FSM stays ACTIVE, and frame_err pulses together with that pixel's out_valid.
REQ-034 When an accepted sof pixel coincides with the final pixel position, SHALL treat it as a restart per REQ-033 (no out_eof).
REQ-035 out_eol, out_eof and frame_err SHALL be 0 whenever out_valid=0.

Reset
REQ-036 While rst_n=0 at a clock edge: FSM=IDLE, x=y=0, and all outputs 0 (out_valid, out_cur, out_up, out_x, out_y, out_eol, out_eof, busy, frame_err, ram_we, ram_di, ram_waddr, ram_raddr).
REQ-037 Reset mid-frame SHALL discard the frame and does not clear RAM; the next frame's row 0 is still masked per REQ-030.

Verification (IMG_W=4, IMG_H=3)
REQ-038 Reset, then a 12-pixel frame 1,0,1,1 / 0,1,1,0 / 1,1,0,0 with sof on the first pixel -> row-1 out_up = 1,0,1,1; row-2 out_up = 0,1,1,0; row-0 out_up = 0; eol at x=3; eof only on the 12th output; busy falls after the 12th accept.
REQ-039 Same frame with in_valid=0 gaps of 1-3 cycles -> identical out stream, each out_valid exactly 1 cycle after its accept, x/y frozen during gaps.
REQ-040 in_valid=1 without sof while IDLE -> no ram_we and no out_valid; a later sof starts at (0,0).
REQ-041 sof at pixel (2,1) -> frame_err=1 on that output, out_x=0, out_y=0, out_up=0; the following frame completes normally.
REQ-042 rst_n=0 for 1 cycle at pixel (1,2), then a new frame of all 1s -> row-0 out_up=0 despite stale RAM; rows 1-2 out_up=1.

Source files
------------

// File: rtl/linebuf_ctrl_if.sv
// Line RAM port bundle between linebuf_ctrl and a 1-bit line RAM.
// master: controller side (we/addrs/di out, dout in); slave: RAM side.
interface linebuf_ctrl_if #(
  parameter int AW = 11
);
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic          ram_di;
  logic          ram_dout;

  modport master (
    output ram_we,
    output ram_waddr,
    output ram_raddr,
    output ram_di,
    input  ram_dout
  );

  modport slave (
    input  ram_we,
    input  ram_waddr,
    input  ram_raddr,
    input  ram_di,
    output ram_dout
  );
endinterface

// File: rtl/linebuf_ctrl.sv
// Binary line-buffer controller: pairs each pixel with the pixel above it.
// Ports: clk, rst_n (sync, active-low); in_* pixel stream; ram bus (master);
// out_* pixel pair stream with x/y/eol/eof; busy; frame_err.
module linebuf_ctrl #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_pixel,
  linebuf_ctrl_if.master ram,
  output logic          out_valid,
  output logic          out_cur,
  output logic          out_up,
  output logic [AW-1:0] out_x,
  output logic [8:0]    out_y,
  output logic          out_eol,
  output logic          out_eof,
  output logic          busy,
  output logic          frame_err
);

  localparam logic [AW-1:0] XMAX = AW'(IMG_W - 1);
  localparam logic [8:0]    YMAX = 9'(IMG_H - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] x_q, x_d;
  logic [8:0]    y_q, y_d;

  logic          out_valid_q, out_valid_d;
  logic          out_cur_q, out_cur_d;
  logic [AW-1:0] out_x_q, out_x_d;
  logic [8:0]    out_y_q, out_y_d;
  logic          out_eol_q, out_eol_d;
  logic          out_eof_q, out_eof_d;
  logic          frame_err_q, frame_err_d;

  logic          accept;
  logic          restart;
  logic          last;
  logic          at_xmax;
  logic          at_ymax;
  logic [AW-1:0] ax;
  logic [8:0]    ay;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    out_cur_d   = out_cur_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_eol_d   = 1'b0;
    out_eof_d   = 1'b0;
    frame_err_d = 1'b0;

    accept  = 1'b0;
    restart = 1'b0;
    // A sof pixel always lands at the origin, whatever the counters say.
    ax      = in_sof ? '0 : x_q;
    ay      = in_sof ? '0 : y_q;
    at_xmax = (ax == XMAX);
    at_ymax = (ay == YMAX);

    case (state_q)
      IDLE: begin
        accept = in_valid & in_sof;
      end
      ACTIVE: begin
        accept  = in_valid;
        restart = in_valid & in_sof;
      end
      default: begin
        accept = 1'b0;
      end
    endcase

    // A sof never closes a frame, even at the final position.
    last = accept & at_xmax & at_ymax & ~in_sof;

    if (accept) begin
      state_d = ACTIVE;
      if (at_xmax) begin
        x_d = '0;
        y_d = at_ymax ? 9'd0 : ay + 9'd1;
      end else begin
        x_d = ax + AW'(1);
        y_d = ay;
      end
      if (last) begin
        state_d = IDLE;
      end
      out_valid_d = 1'b1;
      out_cur_d   = in_pixel;
      out_x_d     = ax;
      out_y_d     = ay;
      out_eol_d   = at_xmax;
      out_eof_d   = last;
      frame_err_d = restart;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_cur_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_cur_q   <= out_cur_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Read and write share one address: the RAM returns the old word
  // (previous line) while the new pixel overwrites it.
  assign ram.ram_we    = rst_n & accept;
  assign ram.ram_waddr = !rst_n ? '0 : (accept ? ax : x_q);
  assign ram.ram_raddr = !rst_n ? '0 : (accept ? ax : x_q);
  assign ram.ram_di    = rst_n & accept & in_pixel;

  // Row 0 has no line above; RAM there holds stale data.
  assign out_up    = (out_y_q != 9'd0) & ram.ram_dout;
  assign out_valid = out_valid_q;
  assign out_cur   = out_cur_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl at a 4x3 image size.
// Image-level reference model plus literal checks of captured streams.
module tb_linebuf_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_pixel = 1'b0;
  logic          out_valid, out_cur, out_up;
  logic [AW-1:0] out_x;
  logic [8:0]    out_y;
  logic          out_eol, out_eof, busy, frame_err;

  linebuf_ctrl_if #(.AW(AW)) rif ();

  linebuf_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .ram       (rif.master),
    .out_valid (out_valid),
    .out_cur   (out_cur),
    .out_up    (out_up),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // 1-bit line RAM: 1-cycle read latency, read-before-write.
  logic mem [W];
  initial for (int i = 0; i < W; i++) mem[i] = 1'b0;
  always @(posedge clk) begin
    rif.ram_dout <= mem[rif.ram_raddr[1:0]];
    if (rif.ram_we) mem[rif.ram_waddr[1:0]] <= rif.ram_di;
  end

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
  endtask

  // Image-level model: current frame contents plus position.
  bit img [H][W];
  int mx = 0, my = 0;
  bit mact = 0;

  bit e_rst = 1, e_valid = 0, e_cur = 0, e_up = 0;
  bit e_eol = 0, e_eof = 0, e_err = 0, e_busy = 0;
  int e_x = 0, e_y = 0;
  bit chk_en = 0;

  logic [11:0] up_hist = '0;
  int eof_cnt = 0;
  int err_cnt = 0;
  logic [31:0] err_info = '0;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (e_rst) begin
        chk("rst_outs", {out_valid, out_cur, out_up, out_x, out_y, out_eol,
                         out_eof, busy, frame_err}, '0);
        chk("rst_ram", {rif.ram_we, rif.ram_di, rif.ram_waddr,
                        rif.ram_raddr}, '0);
      end else begin
        chk("out_valid", out_valid, e_valid);
        chk("busy", busy, e_busy);
        if (e_valid) begin
          chk("out_cur", out_cur, e_cur);
          chk("out_up", out_up, e_up);
          chk("out_x", out_x, e_x);
          chk("out_y", out_y, e_y);
          chk("out_eol", out_eol, e_eol);
          chk("out_eof", out_eof, e_eof);
          chk("frame_err", frame_err, e_err);
        end else begin
          chk("flags_idle", {out_eol, out_eof, frame_err}, 0);
        end
      end
      if (out_valid === 1'b1) begin
        up_hist = {up_hist[10:0], out_up};
        if (out_eof) eof_cnt++;
        if (frame_err) begin
          err_cnt++;
          err_info = {out_up, out_y[7:0], out_x[7:0]};
        end
      end
    end
  end

  task automatic rst_cycle();
    @(negedge clk);
    rst_n = 0; in_valid = 0; in_sof = 0; in_pixel = 0;
    mact = 0; mx = 0; my = 0;
    e_rst = 1; e_valid = 0; e_busy = 0;
    chk_en = 1;
  endtask

  task automatic drive(input bit v, input bit s, input bit p);
    bit acc;
    int ax, ay;
    @(negedge clk);
    rst_n = 1; in_valid = v; in_sof = s; in_pixel = p;
    acc = v && (mact || s);
    e_rst = 0;
    e_valid = acc;
    e_err = 0; e_eol = 0; e_eof = 0;
    ax = mx; ay = my;
    if (acc) begin
      if (s) begin
        e_err = mact;
        ax = 0; ay = 0;
        mact = 1;
      end
      img[ay][ax] = p;
      e_cur = p;
      e_up = (ay > 0) ? img[ay-1][ax] : 1'b0;
      e_x = ax; e_y = ay;
      e_eol = (ax == W - 1);
      e_eof = (ax == W - 1) && (ay == H - 1) && !s;
      mx = ax + 1; my = ay;
      if (mx == W) begin
        mx = 0;
        my = ay + 1;
        if (my == H) begin
          my = 0;
          mact = 0;
        end
      end
    end
    e_busy = mact;
    #1;
    chk("ram_we", rif.ram_we, acc);
    chk("ram_addr", {rif.ram_waddr, rif.ram_raddr}, {AW'(ax), AW'(ax)});
    if (acc) chk("ram_di", rif.ram_di, p);
  endtask

  task automatic frame(input logic [11:0] pat, input bit gaps);
    for (int i = 0; i < 12; i++) begin
      drive(1, i == 0, pat[11-i]);
      if (gaps) repeat ((i % 3) + 1) drive(0, 0, 0);
    end
  endtask

  localparam logic [11:0] PAT = 12'b1011_0110_1100;

  initial begin
    rst_cycle();
    rst_cycle();

    // Plain frame
    up_hist = '0; eof_cnt = 0;
    frame(PAT, 0);
    drive(0, 0, 0);
    chk("lit_up_plain", up_hist, 12'b0000_1011_0110);
    chk("lit_eof_plain", eof_cnt, 1);
    chk("lit_busy_after", busy, 0);

    // Same frame with stalls
    up_hist = '0; eof_cnt = 0;
    frame(PAT, 1);
    drive(0, 0, 0);
    chk("lit_up_gaps", up_hist, 12'b0000_1011_0110);
    chk("lit_eof_gaps", eof_cnt, 1);

    // Non-sof pixels while idle are ignored
    repeat (3) drive(1, 0, 1);
    drive(0, 0, 0);

    // Restart at (2,1)
    err_cnt = 0; eof_cnt = 0;
    for (int i = 0; i < 6; i++) drive(1, i == 0, 1);
    frame(12'b0110_1001_1110, 0);
    drive(0, 0, 0);
    chk("lit_err_cnt", err_cnt, 1);
    chk("lit_err_pos", err_info, 32'h0);
    chk("lit_eof_restart", eof_cnt, 1);

    // Reset mid-frame at (1,2), then an all-ones frame
    for (int i = 0; i < 9; i++) drive(1, i == 0, 1);
    rst_cycle();
    up_hist = '0; eof_cnt = 0;
    frame(12'hFFF, 0);
    drive(0, 0, 0);
    chk("lit_up_ones", up_hist, 12'b0000_1111_1111);
    chk("lit_eof_ones", eof_cnt, 1);

    // sof at the final position restarts, no eof
    eof_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 11; i++) drive(1, i == 0, 0);
    drive(1, 1, 1);
    drive(0, 0, 0);
    chk("lit_sof_last_eof", eof_cnt, 0);
    chk("lit_sof_last_err", err_cnt, 1);
    chk("lit_sof_last_busy", busy, 1);

    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
